// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register file write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_REGS   = 32;

  // Requester indices: ALU writeback and load/memory writeback
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  // One-hot decode of a register address (also used by the register file write decoder)
  function automatic logic [DEF_NUM_REGS-1:0] addr_onehot(input logic [DEF_ADDR_WIDTH-1:0] addr);
    logic [DEF_NUM_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// Single-entry writeback holding buffer: occupancy flag plus address/data payload.
module wb_hold_buffer
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  clearAll,
  input  logic                  load,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] inAddr,
  input  logic [DATA_WIDTH-1:0] inData,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  full_d, full_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;

  // Next state: load wins over clear so the entry can drain and refill in one cycle
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      addr_d = inAddr;
      data_d = inData;
    end else if (clear) begin
      full_d = 1'b0;
    end
  end

  // Occupancy flag, cleared asynchronously so buffered writes are discarded on reset
  always_ff @(posedge clk or posedge clearAll) begin
    if (clearAll) full_q <= 1'b0;
    else          full_q <= full_d;
  end

  // Payload registers; only observed while the entry is full, so no reset
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign full = full_q;
  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register file write port between ALU and load writeback.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  clearAll,
  input  logic                  hold,
  input  logic                  req0Valid,
  output logic                  req0Ready,
  input  logic [ADDR_WIDTH-1:0] req0Addr,
  input  logic [DATA_WIDTH-1:0] req0Data,
  input  logic                  req1Valid,
  output logic                  req1Ready,
  input  logic [ADDR_WIDTH-1:0] req1Addr,
  input  logic [DATA_WIDTH-1:0] req1Data,
  output logic [DATA_WIDTH-1:0] write,
  output logic [ADDR_WIDTH-1:0] addressRD,
  output logic                  writeEnable,
  output logic [NUM_REGS-1:0]   pendingMask
);

  logic [1:0]            full, load, grant;
  logic [ADDR_WIDTH-1:0] buf_addr [2];
  logic [DATA_WIDTH-1:0] buf_data [2];

  // age_q = 1: the load buffer holds the older entry; 0: the ALU buffer does
  logic age_d, age_q;
  // prio_q = 0: requester 0 wins a different-address tie; 1: requester 1 wins
  logic prio_d, prio_q;

  wb_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_alu_buf (
    .clk(clk), .clearAll(clearAll), .load(load[REQ_ALU]), .clear(grant[REQ_ALU]),
    .inAddr(req0Addr), .inData(req0Data),
    .full(full[REQ_ALU]), .addr(buf_addr[REQ_ALU]), .data(buf_data[REQ_ALU])
  );

  wb_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_load_buf (
    .clk(clk), .clearAll(clearAll), .load(load[REQ_LOAD]), .clear(grant[REQ_LOAD]),
    .inAddr(req1Addr), .inData(req1Data),
    .full(full[REQ_LOAD]), .addr(buf_addr[REQ_LOAD]), .data(buf_data[REQ_LOAD])
  );

  // Ready depends only on buffer state and grant, never on valid
  assign req0Ready = !full[REQ_ALU]  || grant[REQ_ALU];
  assign req1Ready = !full[REQ_LOAD] || grant[REQ_LOAD];

  // Writes to x0 complete the handshake but never occupy a buffer
  assign load[REQ_ALU]  = req0Valid && req0Ready && (req0Addr != '0);
  assign load[REQ_LOAD] = req1Valid && req1Ready && (req1Addr != '0);

  // Grant selection: same-address conflicts follow age, otherwise round-robin
  always_comb begin
    grant = 2'b00;
    if (!hold) begin
      if (full[REQ_ALU] && !full[REQ_LOAD]) begin
        grant[REQ_ALU] = 1'b1;
      end else if (!full[REQ_ALU] && full[REQ_LOAD]) begin
        grant[REQ_LOAD] = 1'b1;
      end else if (full[REQ_ALU] && full[REQ_LOAD]) begin
        if (buf_addr[REQ_ALU] == buf_addr[REQ_LOAD]) begin
          if (age_q) grant[REQ_LOAD] = 1'b1;
          else       grant[REQ_ALU]  = 1'b1;
        end else if (prio_q) begin
          grant[REQ_LOAD] = 1'b1;
        end else begin
          grant[REQ_ALU] = 1'b1;
        end
      end
    end
  end

  // Next age/prio: the buffer that stays full across another's load is the older one
  always_comb begin
    age_d  = age_q;
    prio_d = prio_q;
    if (load[REQ_ALU] && load[REQ_LOAD])                              age_d = 1'b1;
    else if (load[REQ_ALU] && full[REQ_LOAD] && !grant[REQ_LOAD])     age_d = 1'b1;
    else if (load[REQ_LOAD] && full[REQ_ALU] && !grant[REQ_ALU])      age_d = 1'b0;
    if (grant[REQ_ALU])  prio_d = 1'b1;
    if (grant[REQ_LOAD]) prio_d = 1'b0;
  end

  // Arbitration state registers
  always_ff @(posedge clk or posedge clearAll) begin
    if (clearAll) begin
      age_q  <= 1'b0;
      prio_q <= 1'b0;
    end else begin
      age_q  <= age_d;
      prio_q <= prio_d;
    end
  end

  // Write port mux of the granted buffer; all zero when idle
  always_comb begin
    write       = '0;
    addressRD   = '0;
    writeEnable = 1'b0;
    if (grant[REQ_ALU]) begin
      write       = buf_data[REQ_ALU];
      addressRD   = buf_addr[REQ_ALU];
      writeEnable = 1'b1;
    end else if (grant[REQ_LOAD]) begin
      write       = buf_data[REQ_LOAD];
      addressRD   = buf_addr[REQ_LOAD];
      writeEnable = 1'b1;
    end
  end

  // Pending mask covers every full buffer, including the one being written now
  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < 2; i++) begin
      if (full[i]) pendingMask = pendingMask | NUM_REGS'(addr_onehot(buf_addr[i]));
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench with a write-order scoreboard and a shadow register file.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        clearAll;
  logic        hold;
  logic        req0Valid, req0Ready;
  logic [4:0]  req0Addr;
  logic [31:0] req0Data;
  logic        req1Valid, req1Ready;
  logic [4:0]  req1Addr;
  logic [31:0] req1Data;
  logic [31:0] write;
  logic [4:0]  addressRD;
  logic        writeEnable;
  logic [31:0] pendingMask;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] rf [32];
  int          n_assert;
  int          n_fail;

  regfile_write_arbiter dut (
    .clk(clk), .clearAll(clearAll), .hold(hold),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Addr(req0Addr), .req0Data(req0Data),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Addr(req1Addr), .req1Data(req1Data),
    .write(write), .addressRD(addressRD), .writeEnable(writeEnable), .pendingMask(pendingMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endfunction

  function automatic void push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endfunction

  // Shadow register file captures each write at the edge ending the grant cycle
  always @(posedge clk) begin
    if (!clearAll && writeEnable) rf[addressRD] <= write;
  end

  // Scoreboard: every write strobe must match the next expected write in order
  always @(negedge clk) begin
    if (!clearAll && writeEnable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(writeEnable), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(addressRD), 32'(e.a));
        check("wr_data", write, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic r0x, r1x;
    n_assert  = 0;
    n_fail    = 0;
    clearAll  = 1'b1;
    hold      = 1'b0;
    req0Valid = 1'b0; req0Addr = '0; req0Data = '0;
    req1Valid = 1'b0; req1Addr = '0; req1Data = '0;

    // Reset state
    @(negedge clk);
    check("rst_we", 32'(writeEnable), 32'd0);
    check("rst_write", write, 32'd0);
    check("rst_addr", 32'(addressRD), 32'd0);
    check("rst_pending", pendingMask, 32'd0);
    tick();
    clearAll = 1'b0;
    @(negedge clk);
    check("rst_ready0", 32'(req0Ready), 32'd1);
    check("rst_ready1", 32'(req1Ready), 32'd1);

    // Both requesters streaming, distinct addresses: grants alternate 0,1,0,1
    tick();
    req0Valid = 1'b1; req0Addr = 5'd3; req0Data = 32'hA000_0000;
    req1Valid = 1'b1; req1Addr = 5'd7; req1Data = 32'hB000_0000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r0x = (k == 0) || (k % 2 == 1);
      r1x = (k % 2 == 0);
      check("alt_ready0", 32'(req0Ready), 32'(r0x));
      check("alt_ready1", 32'(req1Ready), 32'(r1x));
      if (k > 0) check("alt_we", 32'(writeEnable), 32'd1);
      if (r0x) push(5'd3, req0Data);
      if (r1x) push(5'd7, req1Data);
      tick();
      if (r0x) req0Data = req0Data + 32'd1;
      if (r1x) req1Data = req1Data + 32'd1;
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    @(negedge clk);
    check("alt_drain_we1", 32'(writeEnable), 32'd1);
    check("alt_drain_pend1", pendingMask, 32'h0000_0088);
    @(negedge clk);
    check("alt_drain_we2", 32'(writeEnable), 32'd1);
    check("alt_drain_pend2", pendingMask, 32'h0000_0008);
    @(negedge clk);
    check("alt_idle_we", 32'(writeEnable), 32'd0);
    check("alt_idle_pend", pendingMask, 32'd0);

    // Single ALU write to x5
    tick();
    req0Valid = 1'b1; req0Addr = 5'd5; req0Data = 32'h0000_00AA;
    @(negedge clk);
    check("a_ready0", 32'(req0Ready), 32'd1);
    push(5'd5, 32'h0000_00AA);
    tick();
    req0Valid = 1'b0;
    @(negedge clk);
    check("a_pending", pendingMask, 32'h0000_0020);
    check("a_we", 32'(writeEnable), 32'd1);
    tick();
    @(negedge clk);
    check("a_pending_clr", pendingMask, 32'd0);
    check("a_we_clr", 32'(writeEnable), 32'd0);

    // Write to x0: handshake completes, nothing is buffered
    req0Valid = 1'b1; req0Addr = 5'd0; req0Data = 32'hFFFF_FFFF;
    #1;
    check("x0_ready0", 32'(req0Ready), 32'd1);
    tick();
    req0Valid = 1'b0;
    @(negedge clk);
    check("x0_we", 32'(writeEnable), 32'd0);
    check("x0_pending", pendingMask, 32'd0);
    tick();
    @(negedge clk);
    check("x0_we2", 32'(writeEnable), 32'd0);

    // Same destination x9 from both at one edge: load is older and writes first
    req0Valid = 1'b1; req0Addr = 5'd9; req0Data = 32'h2222_0009;
    req1Valid = 1'b1; req1Addr = 5'd9; req1Data = 32'h1111_0009;
    #1;
    check("x9_ready0", 32'(req0Ready), 32'd1);
    check("x9_ready1", 32'(req1Ready), 32'd1);
    push(5'd9, 32'h1111_0009);
    push(5'd9, 32'h2222_0009);
    tick();
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    @(negedge clk);
    check("x9_pending1", pendingMask, 32'h0000_0200);
    check("x9_we1", 32'(writeEnable), 32'd1);
    tick();
    @(negedge clk);
    check("x9_pending2", pendingMask, 32'h0000_0200);
    check("x9_we2", 32'(writeEnable), 32'd1);
    tick();
    @(negedge clk);
    check("x9_we_idle", 32'(writeEnable), 32'd0);
    check("x9_final", rf[9], 32'h2222_0009);

    // Hold with both buffers full (x2, x4)
    hold = 1'b1;
    req0Valid = 1'b1; req0Addr = 5'd2; req0Data = 32'h0C0C_0002;
    req1Valid = 1'b1; req1Addr = 5'd4; req1Data = 32'h0D0D_0004;
    #1;
    check("hold_load_ready0", 32'(req0Ready), 32'd1);
    check("hold_load_ready1", 32'(req1Ready), 32'd1);
    tick();
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("hold_we", 32'(writeEnable), 32'd0);
      check("hold_ready0", 32'(req0Ready), 32'd0);
      check("hold_ready1", 32'(req1Ready), 32'd0);
      check("hold_pending", pendingMask, 32'h0000_0014);
      tick();
    end
    // Round-robin pointer favours requester 1 after the last grant went to requester 0
    push(5'd4, 32'h0D0D_0004);
    push(5'd2, 32'h0C0C_0002);
    hold = 1'b0;
    @(negedge clk);
    check("hold_rel_we1", 32'(writeEnable), 32'd1);
    check("hold_rel_ready1", 32'(req1Ready), 32'd1);
    check("hold_rel_ready0", 32'(req0Ready), 32'd0);
    tick();
    @(negedge clk);
    check("hold_rel_we2", 32'(writeEnable), 32'd1);
    tick();
    @(negedge clk);
    check("hold_rel_idle", 32'(writeEnable), 32'd0);

    // Asynchronous reset mid-operation discards both buffered writes
    req0Valid = 1'b1; req0Addr = 5'd10; req0Data = 32'h0000_000A;
    req1Valid = 1'b1; req1Addr = 5'd11; req1Data = 32'h0000_000B;
    tick();
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    check("mid_we_before", 32'(writeEnable), 32'd1);
    check("mid_pend_before", pendingMask, 32'h0000_0C00);
    clearAll = 1'b1;
    #1;
    check("mid_rst_we", 32'(writeEnable), 32'd0);
    check("mid_rst_pending", pendingMask, 32'd0);
    check("mid_rst_write", write, 32'd0);
    check("mid_rst_addr", 32'(addressRD), 32'd0);
    #1;
    clearAll = 1'b0;
    #1;
    check("mid_ready0", 32'(req0Ready), 32'd1);
    check("mid_ready1", 32'(req1Ready), 32'd1);
    @(negedge clk);
    check("mid_we_after", 32'(writeEnable), 32'd0);
    check("mid_pend_after", pendingMask, 32'd0);
    tick();
    @(negedge clk);
    check("mid_we_after2", 32'(writeEnable), 32'd0);

    // End-of-run checks on the shadow register file and scoreboard
    check("rf_x3", rf[3], 32'hA000_0003);
    check("rf_x7", rf[7], 32'hB000_0002);
    check("rf_x5", rf[5], 32'h0000_00AA);
    check("rf_x2", rf[2], 32'h0C0C_0002);
    check("rf_x4", rf[4], 32'h0D0D_0004);
    check("sb_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
